// File: rtl/burst_mem_model_pkg.sv
// Shared types for the burst memory model.
// Holds the FSM state encoding, the burst counter width and a length helper.
package burst_mem_model_pkg;

    localparam int BURST_CNT_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WR_BURST = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_DRAIN = 2'd3
    } state_e;

    // A burst count of zero still moves one beat.
    function automatic logic [BURST_CNT_W-1:0] eff_len(
        input logic [BURST_CNT_W-1:0] c
    );
        return (c == '0) ? BURST_CNT_W'(1) : c;
    endfunction

endpackage

// File: rtl/burst_mem_rd_fifo.sv
// Read-return buffer: ring FIFO, valid/ready on the output side.
// Ports: clk, rst, in_vld/in_dat (push), out_vld/out_dat/out_rdy (pop), count.
module burst_mem_rd_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_vld,
    input  logic [DATA_W-1:0]          in_dat,
    output logic                       out_vld,
    output logic [DATA_W-1:0]          out_dat,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] slot_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign out_vld = (count != '0);
    assign out_dat = slot_q[rd_ptr];
    assign push    = in_vld && (count != CNT_W'(DEPTH));
    assign pop     = out_vld && out_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            unique case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) slot_q[wr_ptr] <= in_dat;
    end

endmodule

// File: rtl/burst_mem_model.sv
// Behavioural burst memory with byte-masked write bursts and pipelined reads.
// Ports: wrap_mem_* requests in, mem_wrap_rdy accept, mem_wrap_rd_data* return.
module burst_mem_model
    import burst_mem_model_pkg::*;
#(
    parameter int MEM_ADDR_W    = 10,
    parameter int MEM_DATA_W    = 512,
    parameter int MEM_WR_MASK_W = MEM_DATA_W/8,
    parameter int RD_LATENCY    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wrap_mem_write_en,
    input  logic [MEM_ADDR_W-1:0]    wrap_mem_addr,
    input  logic [MEM_DATA_W-1:0]    wrap_mem_wr_data,
    input  logic [MEM_WR_MASK_W-1:0] wrap_mem_byte_en,
    input  logic [BURST_CNT_W-1:0]   wrap_mem_burst_cnt,
    input  logic                     wrap_mem_read_en,
    output logic                     mem_wrap_rdy,
    output logic                     mem_wrap_rd_data_val,
    output logic [MEM_DATA_W-1:0]    mem_wrap_rd_data,
    input  logic                     wrap_mem_rd_data_rdy
);

    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int CNT_W      = $clog2(FIFO_DEPTH+1);

    state_e                  state;
    logic [MEM_DATA_W-1:0]   mem [2**MEM_ADDR_W];
    logic [MEM_ADDR_W-1:0]   wr_addr;
    logic [MEM_ADDR_W-1:0]   rd_addr;
    logic [MEM_ADDR_W-1:0]   mem_waddr;
    logic [BURST_CNT_W-1:0]  wr_left;
    logic [BURST_CNT_W-1:0]  rd_left;
    logic [BURST_CNT_W-1:0]  ret_left;
    logic [BURST_CNT_W-1:0]  burst_len;
    logic [CNT_W-1:0]        fifo_cnt;
    logic [CNT_W-1:0]        fifo_free;
    logic [CNT_W-1:0]        inflight;
    logic                    cmd_rdy;
    logic                    mem_we;
    logic                    issue;
    logic                    push_vld;
    logic                    fifo_vld;
    logic                    pop;
    logic [MEM_DATA_W-1:0]   rd_word;
    logic [MEM_DATA_W-1:0]   push_dat;

    assign cmd_rdy      = (state == ST_IDLE) || (state == ST_WR_BURST);
    assign mem_wrap_rdy = !rst && cmd_rdy;
    assign mem_we       = mem_wrap_rdy && wrap_mem_write_en;
    assign mem_waddr    = (state == ST_IDLE) ? wrap_mem_addr : wr_addr;
    assign burst_len    = eff_len(wrap_mem_burst_cnt);
    assign fifo_free    = CNT_W'(FIFO_DEPTH) - fifo_cnt;
    // Only issue when every read already in the pipe still has a slot.
    assign issue        = (state == ST_RD_ISSUE) && (fifo_free > inflight);
    assign rd_word      = mem[rd_addr];

    assign mem_wrap_rd_data_val = !rst && fifo_vld;
    assign pop = mem_wrap_rd_data_val && wrap_mem_rd_data_rdy;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < MEM_WR_MASK_W; b++) begin
                if (wrap_mem_byte_en[b])
                    mem[mem_waddr][b*8 +: 8] <= wrap_mem_wr_data[b*8 +: 8];
            end
        end
    end

    // The FIFO entry register is the last latency stage, so the pipe
    // itself carries RD_LATENCY-1 registers.
    if (RD_LATENCY == 1) begin : g_nopipe
        assign push_vld = issue;
        assign push_dat = rd_word;
    end else begin : g_pipe
        logic [RD_LATENCY-2:0] vld_q;
        logic [MEM_DATA_W-1:0] dat_q [RD_LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= issue;
                for (int k = 1; k < RD_LATENCY-1; k++)
                    vld_q[k] <= vld_q[k-1];
            end
        end

        always_ff @(posedge clk) begin
            dat_q[0] <= rd_word;
            for (int k = 1; k < RD_LATENCY-1; k++)
                dat_q[k] <= dat_q[k-1];
        end

        assign push_vld = vld_q[RD_LATENCY-2];
        assign push_dat = dat_q[RD_LATENCY-2];
    end

    burst_mem_rd_fifo #(
        .DATA_W (MEM_DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_rd_fifo (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (push_vld),
        .in_dat  (push_dat),
        .out_vld (fifo_vld),
        .out_dat (mem_wrap_rd_data),
        .out_rdy (wrap_mem_rd_data_rdy),
        .count   (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wr_addr  <= '0;
            wr_left  <= '0;
            rd_addr  <= '0;
            rd_left  <= '0;
            ret_left <= '0;
            inflight <= '0;
        end else begin
            unique case ({issue, push_vld})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
            if (issue) rd_addr  <= rd_addr + MEM_ADDR_W'(1);
            if (pop)   ret_left <= ret_left - BURST_CNT_W'(1);
            unique case (state)
                ST_IDLE: begin
                    // Write has priority; a read seen with it is dropped.
                    if (wrap_mem_write_en) begin
                        if (burst_len > BURST_CNT_W'(1)) begin
                            wr_addr <= wrap_mem_addr + MEM_ADDR_W'(1);
                            wr_left <= burst_len - BURST_CNT_W'(1);
                            state   <= ST_WR_BURST;
                        end
                    end else if (wrap_mem_read_en) begin
                        rd_addr  <= wrap_mem_addr;
                        rd_left  <= burst_len;
                        ret_left <= burst_len;
                        state    <= ST_RD_ISSUE;
                    end
                end
                ST_WR_BURST: begin
                    if (wrap_mem_write_en) begin
                        wr_addr <= wr_addr + MEM_ADDR_W'(1);
                        wr_left <= wr_left - BURST_CNT_W'(1);
                        if (wr_left == BURST_CNT_W'(1)) state <= ST_IDLE;
                    end
                end
                ST_RD_ISSUE: begin
                    if (issue) begin
                        rd_left <= rd_left - BURST_CNT_W'(1);
                        if (rd_left == BURST_CNT_W'(1)) state <= ST_RD_DRAIN;
                    end
                end
                ST_RD_DRAIN: begin
                    if (pop && ret_left == BURST_CNT_W'(1)) state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_burst_mem_model.sv
// Scoreboard bench for burst_mem_model with a word-array reference model.
// Driver pushes expected beats; a negedge monitor pops and compares them.
module tb_burst_mem_model;

    localparam int AW    = 10;
    localparam int DW    = 512;
    localparam int MW    = DW/8;
    localparam int LAT   = 4;
    localparam int WORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [MW-1:0] be = '0;
    logic [6:0]    cnt = '0;
    logic          rd_en = 1'b0;
    logic          rdy;
    logic          val;
    logic [DW-1:0] rd_data;
    logic          rd_rdy = 1'b1;

    burst_mem_model #(
        .MEM_ADDR_W    (AW),
        .MEM_DATA_W    (DW),
        .MEM_WR_MASK_W (MW),
        .RD_LATENCY    (LAT)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wrap_mem_write_en    (wr_en),
        .wrap_mem_addr        (addr),
        .wrap_mem_wr_data     (wr_data),
        .wrap_mem_byte_en     (be),
        .wrap_mem_burst_cnt   (cnt),
        .wrap_mem_read_en     (rd_en),
        .mem_wrap_rdy         (rdy),
        .mem_wrap_rd_data_val (val),
        .mem_wrap_rd_data     (rd_data),
        .wrap_mem_rd_data_rdy (rd_rdy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] dat;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [WORDS];
    int            cyc = 0;
    int            rd_mode = 0;
    int            checks = 0;
    int            failures = 0;
    int            pops = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // 0: always ready, 1: toggle, 2: random
    always @(posedge clk) begin
        #1;
        case (rd_mode)
            1:       rd_rdy = ~rd_rdy;
            2:       rd_rdy = 1'($urandom_range(1));
            default: rd_rdy = 1'b1;
        endcase
    end

    logic          prev_stall = 1'b0;
    logic          prev_rst = 1'b1;
    logic [DW-1:0] prev_dat = '0;

    always @(negedge clk) begin
        if (rst) begin
            checks++;
            if (val !== 1'b0 || rdy !== 1'b0) begin
                failures++;
                $display("FAIL rst_outputs val=%b rdy=%b required 0/0",
                         val, rdy);
            end
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_rst) begin
                checks++;
                if (rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL rdy_after_rst got=%b required 1", rdy);
                end
            end
            if (wr_en || rd_en) begin
                checks++;
                if (rdy !== 1'b1) begin
                    failures++;
                    $display("FAIL cmd_rdy cyc=%0d got=%b required 1",
                             cyc, rdy);
                end
            end
            if (exp_q.size() > 0) begin
                checks++;
                if (rdy !== 1'b0) begin
                    failures++;
                    $display("FAIL busy_rdy cyc=%0d got=%b required 0",
                             cyc, rdy);
                end
            end
            if (prev_stall) begin
                checks++;
                if (val !== 1'b1 || rd_data !== prev_dat) begin
                    failures++;
                    $display("FAIL hold cyc=%0d val=%b data=%h required %h",
                             cyc, val, rd_data, prev_dat);
                end
            end
            if (val === 1'b1 && rd_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat cyc=%0d got=%h required none",
                             cyc, rd_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    pops++;
                    if (rd_data !== e.dat) begin
                        failures++;
                        $display("FAIL beat_data got=%h required %h",
                                 rd_data, e.dat);
                    end
                    if (e.cyc >= 0) begin
                        checks++;
                        if (cyc != e.cyc) begin
                            failures++;
                            $display("FAIL beat_cycle got=%0d required %0d",
                                     cyc, e.cyc);
                        end
                    end
                end
            end
            prev_stall = (val === 1'b1) && !rd_rdy;
            prev_dat = rd_data;
        end
        prev_rst = rst;
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [MW-1:0] rand_be();
        logic [MW-1:0] m;
        for (int i = 0; i < MW/32; i++) m[i*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 || rdy !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                $display("FAIL wait_idle timeout left=%0d rdy=%b required 0/1",
                         exp_q.size(), rdy);
                $fatal(1, "bench timeout");
            end
        end
    endtask

    // pat: 0 random, 1 all ones, 2 all zeros; beats from abort_at on are
    // replaced by a reset pulse.
    task automatic wr_burst(input int a, input int n, input logic [MW-1:0] m,
                            input int pat, input int abort_at, input bit gaps);
        int len = (n == 0) ? 1 : n;
        for (int i = 0; i < len && i < abort_at; i++) begin
            logic [DW-1:0] w;
            if (gaps && i > 0 && $urandom_range(3) == 0) begin
                @(negedge clk);
                wr_en = 1'b0;
            end
            w = (pat == 1) ? '1 : (pat == 2) ? '0 : rand_word();
            @(negedge clk);
            wr_en = 1'b1;
            addr = (i == 0) ? AW'(a) : AW'($urandom);
            cnt = (i == 0) ? 7'(n) : 7'($urandom);
            wr_data = w;
            be = m;
            for (int b = 0; b < MW; b++)
                if (m[b]) ref_mem[(a + i) % WORDS][b*8 +: 8] = w[b*8 +: 8];
        end
        @(negedge clk);
        wr_en = 1'b0;
        if (abort_at < len) begin
            @(posedge clk);
            #1 rst = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic rd_cmd(input int a, input int n);
        int len = (n == 0) ? 1 : n;
        int t;
        @(negedge clk);
        rd_en = 1'b1;
        addr = AW'(a);
        cnt = 7'(n);
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        addr = AW'($urandom);
        cnt = 7'($urandom);
        t = cyc - 1;
        for (int i = 0; i < len; i++)
            exp_q.push_back('{ref_mem[(a + i) % WORDS],
                              (rd_mode == 0) ? t + 1 + LAT + i : -1});
    endtask

    task automatic rd_burst(input int a, input int n);
        rd_cmd(a, n);
        wait_idle();
    endtask

    task automatic simul_cmd(input int a);
        logic [DW-1:0] w = rand_word();
        @(negedge clk);
        wr_en = 1'b1;
        rd_en = 1'b1;
        addr = AW'(a);
        cnt = 7'd1;
        wr_data = w;
        be = '1;
        ref_mem[a % WORDS] = w;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        repeat (LAT + 8) @(negedge clk);
    endtask

    initial begin
        int a;
        int p0;
        int n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        a = 0;
        while (a < WORDS) begin
            n = (WORDS - a > 127) ? 127 : WORDS - a;
            wr_burst(a, n, '1, 0, 1000, 0);
            a += n;
        end

        wr_burst('h010, 1, '1, 0, 1000, 0);
        rd_burst('h010, 1);

        wr_burst('h3FE, 4, '1, 0, 1000, 0);
        rd_burst('h3FE, 4);
        rd_burst('h000, 2);

        wr_burst('h020, 1, '1, 1, 1000, 0);
        wr_burst('h020, 1, MW'(64'hF), 2, 1000, 0);
        rd_burst('h020, 1);

        wr_burst('h030, 0, '1, 0, 1000, 0);
        rd_burst('h030, 0);

        rd_mode = 1;
        rd_burst('h100, 16);
        rd_mode = 0;
        @(negedge clk);

        simul_cmd('h040);
        rd_burst('h040, 1);

        rd_cmd('h080, 8);
        p0 = pops;
        n = 0;
        while (pops < p0 + 2) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL rst_read_wait pops=%0d required %0d",
                         pops - p0, 2);
                $fatal(1, "bench timeout");
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        rd_burst('h080, 8);

        wr_burst('h200, 6, '1, 0, 3, 0);
        rd_burst('h200, 6);

        rd_mode = 2;
        rd_burst(1000, 100);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(1) == 1) begin
                wr_burst($urandom_range(WORDS-1), $urandom_range(8),
                         rand_be(), 0, 1000, 1);
            end else begin
                rd_mode = $urandom_range(2);
                @(negedge clk);
                rd_burst($urandom_range(WORDS-1), $urandom_range(16));
            end
        end
        rd_mode = 0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
